bcd_scan_scheduler: RTL

//  Time-multiplexes one shared 8-bit-to-BCD converter (0..59 range) between the hour, minute and second

---
 rtl/bcd_scan_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_scheduler.sv
// Shares one BCD converter across hour/min/sec and scans six digits onto a muxed 7-seg display.
// Latency: snapshot at SNAP, one CONV cycle per field, then SCAN_DIV cycles per digit (frame = 1+3*(1+2*SCAN_DIV)).
// Backpressure: time_busy holds the scheduler in SNAP (display dark) until the counters are stable.
module bcd_scan_scheduler #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour_in,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  input  logic       time_busy,
  input  logic [2:0] blink_sel,
  output logic [7:0] conv_decimal,
  input  logic [3:0] conv_higher,
  input  logic [3:0] conv_lower,
  output logic [3:0] digit_bcd,
  output logic [5:0] digit_sel,
  output logic       frame_done,
  output logic       range_err
);

  localparam int DW  = $clog2(SCAN_DIV + 1);
  localparam int FW  = $clog2(BLINK_FRAMES + 1);
  localparam int PEN = (SCAN_DIV >= 2) ? SCAN_DIV - 2 : 0;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_PEN  = DW'(PEN);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {SNAP, CONV, SHOW_HI, SHOW_LO} state_t;

  state_t        state;
  logic [1:0]    fld;          // 0 hour, 1 min, 2 sec
  logic [DW-1:0] dwell;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  // Hour goes straight into conv_decimal at the latch, so only min/sec need holding.
  logic [7:0]    snap_min;
  logic [7:0]    snap_sec;
  logic [2:0]    fld_ok;       // indexed by fld
  logic [3:0]    hi_q;
  logic [3:0]    lo_q;
  logic [5:0]    sel_raw;
  logic          blank;

  // Digit strobe bits for the current field; tens sit one position above ones.
  function automatic logic [5:0] tens_bit(input logic [1:0] f);
    case (f)
      2'd0:    tens_bit = 6'b100000;
      2'd1:    tens_bit = 6'b001000;
      default: tens_bit = 6'b000010;
    endcase
  endfunction

  function automatic logic [5:0] ones_bit(input logic [1:0] f);
    case (f)
      2'd0:    ones_bit = 6'b010000;
      2'd1:    ones_bit = 6'b000100;
      default: ones_bit = 6'b000001;
    endcase
  endfunction

  // Blink masks the strobe only; blink_sel is live so set-mode edits react immediately.
  always_comb begin
    blank = 1'b0;
    if (blink_phase && (state == SHOW_HI || state == SHOW_LO)) begin
      case (fld)
        2'd0:    blank = blink_sel[2];
        2'd1:    blank = blink_sel[1];
        default: blank = blink_sel[0];
      endcase
    end
  end

  assign digit_sel = blank ? 6'b000000 : sel_raw;

  // Scan FSM: snapshot, per-field conversion, dwell timing, blink frame counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SNAP;
      fld          <= 2'd0;
      dwell        <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      snap_min     <= 8'd0;
      snap_sec     <= 8'd0;
      fld_ok       <= 3'b000;
      hi_q         <= 4'd0;
      lo_q         <= 4'd0;
      sel_raw      <= 6'd0;
      conv_decimal <= 8'd0;
      digit_bcd    <= 4'd0;
      frame_done   <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (frame_done) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      case (state)
        SNAP: begin
          sel_raw <= 6'd0;
          if (!time_busy) begin
            snap_min     <= min_in;
            snap_sec     <= sec_in;
            fld_ok       <= {sec_in <= 8'd59, min_in <= 8'd59, hour_in <= 8'd23};
            range_err    <= (hour_in > 8'd23) || (min_in > 8'd59) || (sec_in > 8'd59);
            conv_decimal <= hour_in;
            fld          <= 2'd0;
            dwell        <= '0;
            state        <= CONV;
          end
        end

        CONV: begin
          // Converter output is only trusted for in-range fields; otherwise show blank/error.
          hi_q      <= fld_ok[fld] ? conv_higher : 4'hF;
          lo_q      <= fld_ok[fld] ? conv_lower  : 4'hF;
          digit_bcd <= fld_ok[fld] ? conv_higher : 4'hF;
          sel_raw   <= tens_bit(fld);
          dwell     <= '0;
          state     <= SHOW_HI;
        end

        SHOW_HI: begin
          if (dwell == DWELL_LAST) begin
            dwell     <= '0;
            digit_bcd <= lo_q;
            sel_raw   <= ones_bit(fld);
            state     <= SHOW_LO;
            // With a one-cycle dwell the first SHOW_LO(sec) cycle is already the last.
            if (SCAN_DIV == 1 && fld == 2'd2) frame_done <= 1'b1;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        SHOW_LO: begin
          if (SCAN_DIV >= 2 && fld == 2'd2 && dwell == DWELL_PEN) frame_done <= 1'b1;
          if (dwell == DWELL_LAST) begin
            dwell   <= '0;
            sel_raw <= 6'd0;
            if (fld == 2'd2) begin
              state <= SNAP;
            end else begin
              conv_decimal <= (fld == 2'd0) ? snap_min : snap_sec;
              fld          <= fld + 2'd1;
              state        <= CONV;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        default: state <= SNAP;
      endcase
    end
  end

endmodule
